// File: rtl/wb_result_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_result_arbiter_pkg: shared types for the write-back arbiter        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package wb_result_arbiter_pkg;
  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 4;
  localparam int unsigned NR_WB_PORTS   = 2;

  typedef logic [XLEN-1:0] xlen_t;

  typedef struct packed {
    xlen_t cause;
    xlen_t tval;
    logic  valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    xlen_t                    result;
    exception_t               ex;
  } wb_entry_t;
endpackage
`default_nettype wire

// File: rtl/wb_port_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_port_fifo: per-port result FIFO; caller handles fall-through       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_port_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     usage_o,
  output logic [Width-1:0]           head_o
);
  localparam int unsigned AddrW  = $clog2(Depth);
  localparam int unsigned UsageW = AddrW + 1;

  logic [Depth-1:0][Width-1:0] mem_q, mem_d;
  logic [AddrW-1:0]            rd_q, rd_d, wr_q, wr_d;
  logic [UsageW-1:0]           usage_q, usage_d;
  logic                        push_eff, pop_eff;

  // A push into a full FIFO is accepted only when the head leaves this cycle
  assign pop_eff  = pop_i & (usage_q != '0);
  assign push_eff = push_i & ((usage_q != UsageW'(Depth)) | pop_eff);

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    usage_d = usage_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      usage_d = '0;
    end else begin
      if (pop_eff) rd_d = rd_q + AddrW'(1);
      if (push_eff) begin
        mem_d[wr_q] = data_i;
        wr_d        = wr_q + AddrW'(1);
      end
      usage_d = usage_q + UsageW'(push_eff) - UsageW'(pop_eff);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      usage_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      usage_q <= usage_d;
    end
  end

  assign empty_o = (usage_q == '0);
  assign usage_o = usage_q;
  assign head_o  = mem_q[rd_q];
endmodule
`default_nettype wire

// File: rtl/wb_result_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_result_arbiter: buffers FU results, round-robins them onto WB ports|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_result_arbiter
  import wb_result_arbiter_pkg::*;
#(
  parameter int unsigned NrInPorts   = 5,
  parameter int unsigned NrWbPorts   = NR_WB_PORTS,
  parameter int unsigned FifoDepth   = 2,
  parameter int unsigned TransIdBits = TRANS_ID_BITS
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic       [NrInPorts-1:0]            in_valid_i,
  input  logic       [NrInPorts-1:0][TransIdBits-1:0] in_trans_id_i,
  input  logic       [NrInPorts-1:0][XLEN-1:0]  in_result_i,
  input  exception_t [NrInPorts-1:0]            in_ex_i,
  output logic       [NrInPorts-1:0]            in_stall_o,
  output logic       [NrWbPorts-1:0]            wb_valid_o,
  output logic       [NrWbPorts-1:0][TransIdBits-1:0] wb_trans_id_o,
  output logic       [NrWbPorts-1:0][XLEN-1:0]  wb_result_o,
  output exception_t [NrWbPorts-1:0]            wb_ex_o,
  output logic                                  overflow_o
);
  localparam int unsigned PtrW   = (NrInPorts > 1) ? $clog2(NrInPorts) : 1;
  localparam int unsigned UsageW = $clog2(FifoDepth) + 1;

  typedef struct packed {
    logic [TransIdBits-1:0] trans_id;
    xlen_t                  result;
    exception_t             ex;
  } entry_t;

  entry_t [NrInPorts-1:0]             in_entry, head, cand_entry;
  logic   [NrInPorts-1:0]             empty, full, cand, taken, push, pop, drop;
  logic   [NrInPorts-1:0][UsageW-1:0] usage;

  logic   [NrWbPorts-1:0]             slot_valid;
  logic   [NrWbPorts-1:0][PtrW-1:0]   slot_idx;
  logic   [PtrW:0]                    scan_sum;
  logic   [PtrW-1:0]                  scan_idx, last_idx;

  logic   [PtrW-1:0]                  rr_ptr_q, rr_ptr_d;
  logic   [NrWbPorts-1:0]             wb_valid_q, wb_valid_d;
  entry_t [NrWbPorts-1:0]             wb_q, wb_d;
  logic                               overflow_q, overflow_d;

  for (genvar i = 0; i < NrInPorts; i++) begin : g_port
    assign in_entry[i] = '{trans_id: in_trans_id_i[i], result: in_result_i[i], ex: in_ex_i[i]};

    wb_port_fifo #(
      .Depth (FifoDepth),
      .Width ($bits(entry_t))
    ) i_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (push[i]),
      .data_i  (in_entry[i]),
      .pop_i   (pop[i]),
      .empty_o (empty[i]),
      .usage_o (usage[i]),
      .head_o  (head[i])
    );

    assign full[i]       = (usage[i] == UsageW'(FifoDepth));
    assign in_stall_o[i] = (usage[i] >= UsageW'(FifoDepth - 1));
    // An empty FIFO exposes the incoming pulse directly so latency stays at one cycle
    assign cand[i]       = !flush_i && (!empty[i] || in_valid_i[i]);
    assign cand_entry[i] = empty[i] ? in_entry[i] : head[i];
    assign pop[i]        = taken[i] & !empty[i];
    assign push[i]       = in_valid_i[i] & !flush_i & !(empty[i] & taken[i]) & (!full[i] | pop[i]);
    assign drop[i]       = in_valid_i[i] & !flush_i & full[i] & !pop[i];
  end

  // Slot k takes the first candidate after rr_ptr not already claimed by a lower slot
  always_comb begin
    taken      = '0;
    slot_valid = '0;
    slot_idx   = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int k = 0; k < NrWbPorts; k++) begin
      for (int j = 0; j < NrInPorts; j++) begin
        scan_sum = {1'b0, rr_ptr_q} + (PtrW+1)'(j);
        if (scan_sum >= (PtrW+1)'(NrInPorts)) scan_sum = scan_sum - (PtrW+1)'(NrInPorts);
        scan_idx = scan_sum[PtrW-1:0];
        if (!slot_valid[k] && cand[scan_idx] && !taken[scan_idx]) begin
          slot_valid[k]   = 1'b1;
          slot_idx[k]     = scan_idx;
          taken[scan_idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    last_idx   = rr_ptr_q;
    rr_ptr_d   = rr_ptr_q;
    wb_valid_d = slot_valid;
    wb_d       = wb_q;
    overflow_d = overflow_q | (|drop);
    for (int k = 0; k < NrWbPorts; k++) begin
      if (slot_valid[k]) begin
        wb_d[k]  = cand_entry[slot_idx[k]];
        last_idx = slot_idx[k];
      end
    end
    if (|slot_valid) begin
      rr_ptr_d = (last_idx == PtrW'(NrInPorts - 1)) ? '0 : last_idx + PtrW'(1);
    end
    if (flush_i) rr_ptr_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      wb_valid_q <= '0;
      wb_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_q       <= wb_d;
      overflow_q <= overflow_d;
    end
  end

  for (genvar k = 0; k < NrWbPorts; k++) begin : g_slot
    assign wb_trans_id_o[k] = wb_q[k].trans_id;
    assign wb_result_o[k]   = wb_q[k].result;
    assign wb_ex_o[k]       = wb_q[k].ex;
  end

  assign wb_valid_o = wb_valid_q;
  assign overflow_o = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_wb_result_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_result_arbiter: directed vectors for 2-slot and 1-slot arbiters |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_wb_result_arbiter;
  import wb_result_arbiter_pkg::*;

  localparam int N   = 5;
  localparam int IDW = TRANS_ID_BITS;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic flush;
  logic       [N-1:0]           in_valid;
  logic       [N-1:0][IDW-1:0]  in_id;
  logic       [N-1:0][XLEN-1:0] in_res;
  exception_t [N-1:0]           in_ex;

  logic       [N-1:0]           stall2, stall1;
  logic       [1:0]             wbv2;
  logic       [1:0][IDW-1:0]    wbid2;
  logic       [1:0][XLEN-1:0]   wbres2;
  exception_t [1:0]             wbex2;
  logic                         ovf2, ovf1;
  logic       [0:0]             wbv1;
  logic       [0:0][IDW-1:0]    wbid1;
  logic       [0:0][XLEN-1:0]   wbres1;
  exception_t [0:0]             wbex1;

  wb_result_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
    .in_valid_i(in_valid), .in_trans_id_i(in_id), .in_result_i(in_res), .in_ex_i(in_ex),
    .in_stall_o(stall2), .wb_valid_o(wbv2), .wb_trans_id_o(wbid2),
    .wb_result_o(wbres2), .wb_ex_o(wbex2), .overflow_o(ovf2)
  );

  wb_result_arbiter #(.NrWbPorts(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
    .in_valid_i(in_valid), .in_trans_id_i(in_id), .in_result_i(in_res), .in_ex_i(in_ex),
    .in_stall_o(stall1), .wb_valid_o(wbv1), .wb_trans_id_o(wbid1),
    .wb_result_o(wbres1), .wb_ex_o(wbex1), .overflow_o(ovf1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                 flush;
    logic [N-1:0]         valid;
    logic [N-1:0][IDW-1:0] id;
    logic [1:0]           exp_valid;
    logic [IDW-1:0]       exp_id0;
    logic [IDW-1:0]       exp_id1;
    logic [N-1:0]         exp_stall;
  } vec_t;

  vec_t vecs [9];
  int n_pass  = 0;
  int n_total = 0;

  function automatic vec_t mk(input logic f, input logic [N-1:0] v,
                              input logic [IDW-1:0] i4, i3, i2, i1, i0,
                              input logic [1:0] ev, input logic [IDW-1:0] e0, e1,
                              input logic [N-1:0] es);
    vec_t r;
    r.flush     = f;
    r.valid     = v;
    r.id        = {i4, i3, i2, i1, i0};
    r.exp_valid = ev;
    r.exp_id0   = e0;
    r.exp_id1   = e1;
    r.exp_stall = es;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic clear_in();
    flush    = 1'b0;
    in_valid = '0;
    in_id    = '0;
    in_res   = '0;
    in_ex    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [IDW-1:0] q0 [$];
  logic [IDW-1:0] q4 [$];
  logic [IDW-1:0] exp_id;
  logic           stall_seen;

  initial begin
    vecs[0] = mk(1'b1, 5'b00000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 5'b00000);
    vecs[1] = mk(1'b0, 5'b01011, 0, 4, 0, 2, 1, 2'b11, 1, 2, 5'b01000);
    vecs[2] = mk(1'b0, 5'b00000, 0, 0, 0, 0, 0, 2'b01, 4, 0, 5'b00000);
    vecs[3] = mk(1'b0, 5'b00000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 5'b00000);
    vecs[4] = mk(1'b0, 5'b11111, 9, 8, 7, 6, 5, 2'b11, 9, 5, 5'b01110);
    vecs[5] = mk(1'b0, 5'b00000, 0, 0, 0, 0, 0, 2'b11, 6, 7, 5'b01000);
    vecs[6] = mk(1'b0, 5'b01010, 0, 10, 0, 11, 0, 2'b11, 8, 11, 5'b01000);
    vecs[7] = mk(1'b0, 5'b00000, 0, 0, 0, 0, 0, 2'b01, 10, 0, 5'b00000);
    vecs[8] = mk(1'b0, 5'b00000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 5'b00000);

    clear_in();
    #12;
    chk("reset_wb_valid", 64'(wbv2), 64'd0);
    chk("reset_wb_id", 64'(wbid2), 64'd0);
    chk("reset_wb_result0", 64'(wbres2[0]), 64'd0);
    chk("reset_stall", 64'(stall2), 64'd0);
    chk("reset_overflow", 64'(ovf2), 64'd0);
    chk("reset_wb_valid_1slot", 64'(wbv1), 64'd0);
    @(posedge clk);
    #1 rst_ni = 1'b1;

    // Single result on the load port
    in_valid[1] = 1'b1;
    in_id[1]    = 4'd3;
    in_res[1]   = 64'hDEAD;
    in_ex[1]    = '{cause: 64'd2, tval: 64'd0, valid: 1'b1};
    tick();
    clear_in();
    chk("single_valid", 64'(wbv2), 64'b01);
    chk("single_id", 64'(wbid2[0]), 64'd3);
    chk("single_result", wbres2[0], 64'hDEAD);
    chk("single_ex_valid", 64'(wbex2[0].valid), 64'd1);
    chk("single_ex_cause", wbex2[0].cause, 64'd2);
    chk("single_no_stall", 64'(stall2[1]), 64'd0);
    tick();
    chk("single_oneshot", 64'(wbv2), 64'd0);

    // Table: contention, round-robin resumption, same-cycle push/pop
    for (int v = 0; v < 9; v++) begin
      flush    = vecs[v].flush;
      in_valid = vecs[v].valid;
      in_id    = vecs[v].id;
      for (int i = 0; i < N; i++) in_res[i] = 64'hA5A5_0000_0000_0000 | 64'(in_id[i]);
      tick();
      chk($sformatf("vec%0d_valid", v), 64'(wbv2), 64'(vecs[v].exp_valid));
      chk($sformatf("vec%0d_stall", v), 64'(stall2), 64'(vecs[v].exp_stall));
      if (vecs[v].exp_valid[0]) begin
        chk($sformatf("vec%0d_id0", v), 64'(wbid2[0]), 64'(vecs[v].exp_id0));
        chk($sformatf("vec%0d_res0", v), wbres2[0], 64'hA5A5_0000_0000_0000 | 64'(vecs[v].exp_id0));
      end
      if (vecs[v].exp_valid[1])
        chk($sformatf("vec%0d_id1", v), 64'(wbid2[1]), 64'(vecs[v].exp_id1));
    end
    clear_in();
    chk("table_no_overflow", 64'(ovf2), 64'd0);

    // Fairness on the single-slot arbiter: ports 0 and 4 issue whenever not stalled
    flush = 1'b1;
    tick();
    flush = 1'b0;
    stall_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      in_valid = '0;
      stall_seen = stall_seen | stall1[0] | stall1[4];
      if (!stall1[0]) begin
        in_valid[0] = 1'b1;
        in_id[0]    = {1'b0, 3'(c)};
        q0.push_back(in_id[0]);
      end
      if (!stall1[4]) begin
        in_valid[4] = 1'b1;
        in_id[4]    = {1'b1, 3'(c)};
        q4.push_back(in_id[4]);
      end
      tick();
      chk($sformatf("fair%0d_valid", c), 64'(wbv1), 64'd1);
      chk($sformatf("fair%0d_port", c), 64'(wbid1[0][IDW-1]), 64'(c % 2));
      if (c % 2 == 1) exp_id = (q4.size() > 0) ? q4.pop_front() : '0;
      else            exp_id = (q0.size() > 0) ? q0.pop_front() : '0;
      chk($sformatf("fair%0d_order", c), 64'(wbid1[0]), 64'(exp_id));
    end
    clear_in();
    chk("fair_stall_seen", 64'(stall_seen), 64'd1);
    chk("fair_no_overflow", 64'(ovf1), 64'd0);
    tick();
    tick();

    // Overflow: ports 0-2 ignore stall on the single-slot arbiter
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 5'b00111;
      tick();
      chk($sformatf("ovf_cycle%0d", c), 64'(ovf1), (c == 3) ? 64'd1 : 64'd0);
    end
    clear_in();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ovf_sticky_after_flush", 64'(ovf1), 64'd1);
    chk("ovf_flush_wb_valid", 64'(wbv1), 64'd0);

    // Flush with three entries buffered and a simultaneous port-2 pulse
    tick();
    in_valid = 5'b11111;
    for (int i = 0; i < N; i++) in_id[i] = IDW'(i + 1);
    tick();
    clear_in();
    chk("pre_flush_valid", 64'(wbv2), 64'b11);
    chk("pre_flush_id0", 64'(wbid2[0]), 64'd1);
    chk("pre_flush_id1", 64'(wbid2[1]), 64'd2);
    chk("pre_flush_stall", 64'(stall2), 64'b11100);
    flush       = 1'b1;
    in_valid[2] = 1'b1;
    in_id[2]    = 4'd15;
    tick();
    clear_in();
    chk("flush_wb_valid", 64'(wbv2), 64'd0);
    chk("flush_stall", 64'(stall2), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("post_flush%0d_valid", c), 64'(wbv2), 64'd0);
    end

    // Asynchronous reset with FIFOs partly full
    in_valid = 5'b11111;
    for (int i = 0; i < N; i++) in_id[i] = IDW'(i + 1);
    tick();
    clear_in();
    #2 rst_ni = 1'b0;
    #1;
    chk("areset_wb_valid", 64'(wbv2), 64'd0);
    chk("areset_wb_id", 64'(wbid2), 64'd0);
    chk("areset_stall", 64'(stall2), 64'd0);
    chk("areset_overflow2", 64'(ovf2), 64'd0);
    chk("areset_overflow1", 64'(ovf1), 64'd0);
    chk("areset_wb_valid_1slot", 64'(wbv1), 64'd0);
    @(negedge clk);
    rst_ni      = 1'b1;
    in_valid[2] = 1'b1;
    in_id[2]    = 4'd7;
    in_res[2]   = 64'hBEEF;
    tick();
    clear_in();
    chk("rst_first_valid", 64'(wbv2), 64'b01);
    chk("rst_first_id", 64'(wbid2[0]), 64'd7);
    chk("rst_first_result", wbres2[0], 64'hBEEF);
    chk("rst_first_valid_1slot", 64'(wbv1), 64'd1);
    chk("rst_first_id_1slot", 64'(wbid1[0]), 64'd7);
    chk("rst_first_ex_1slot", 64'(wbex1[0].valid), 64'd0);
    tick();
    chk("rst_no_stale", 64'(wbv2), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
